// File: rtl/core_pkg.sv
// core_pkg: shared widths, writeback FSM states and commit record layout
package core_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int REG_IDX_W = 5;
  typedef enum logic {RUN, HALT} wb_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            is_break;
  } commit_rec_t;
endpackage

// File: rtl/wb_commit_stage_gpr_file.sv
// gpr_file: architectural register file with x0 tied to zero, two comb read ports and a flat view
module gpr_file import core_pkg::*; #(
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  output logic [XLEN-1:0]      rdata1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata2,
  output logic [NREG*XLEN-1:0] flat
);
  logic [XLEN-1:0] regs [NREG];
  logic            wr;
  assign wr = we && waddr != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (wr) regs[waddr] <= wdata;
  // write-first forwarding so decode sees the value retiring this cycle
  assign rdata1 = raddr1 == '0 ? '0 : (BYPASS != 0 && wr && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : (BYPASS != 0 && wr && waddr == raddr2) ? wdata : regs[raddr2];
  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign flat[g*XLEN +: XLEN] = regs[g];
  end
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: retires MEM instructions, writes the GPR file and emits one commit record per instruction
module wb_commit_stage import core_pkg::*; #(
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  output logic                 wb_ready,
  input  logic [XLEN-1:0]      mem_pc,
  input  logic [31:0]          mem_inst,
  input  logic                 mem_rd_we,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_rd_data,
  input  logic                 mem_is_break,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 commit_valid,
  output logic [XLEN-1:0]      commit_pc,
  output logic [31:0]          commit_inst,
  output logic                 commit_is_break,
  output logic [63:0]          commit_cnt,
  output logic [NREG*XLEN-1:0] rf_flat,
  output logic                 halted
);
  wb_state_e   state, state_n;
  commit_rec_t rec;
  logic        accept;
  assign wb_ready = state == RUN;
  assign accept = mem_valid && wb_ready;
  assign halted = state == HALT;
  assign commit_pc = rec.pc;
  assign commit_inst = rec.inst;
  assign commit_is_break = rec.is_break;
  always_comb begin
    state_n = state;
    state_n = (accept && mem_is_break) ? HALT : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      commit_valid <= 1'b0;
      rec <= '0;
      commit_cnt <= '0;
    end else begin
      state <= state_n;
      commit_valid <= accept;
      if (accept) begin
        rec <= '{pc: mem_pc, inst: mem_inst, is_break: mem_is_break};
        commit_cnt <= commit_cnt + 64'd1;
      end
    end
  gpr_file #(.BYPASS(BYPASS)) u_gpr (
    .clk(clk), .rst_n(rst_n),
    .we(accept && mem_rd_we), .waddr(mem_rd), .wdata(mem_rd_data),
    .raddr1(rs1_addr), .rdata1(rs1_data),
    .raddr2(rs2_addr), .rdata2(rs2_data),
    .flat(rf_flat)
  );
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed stimulus against a retire-level model of the commit stage
module tb_wb_commit_stage;
  import core_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid, mem_rd_we, mem_is_break, wb_ready, commit_valid, commit_is_break, halted;
  logic [63:0] mem_pc, mem_rd_data, rs1_data, rs2_data, commit_pc, commit_cnt;
  logic [31:0] mem_inst, commit_inst;
  logic [4:0] mem_rd, rs1_addr, rs2_addr;
  logic [NREG*XLEN-1:0] rf_flat;
  int errs = 0, checks = 0;
  logic [63:0] m_rf [32];
  logic m_valid, m_brk, m_halt;
  logic [63:0] m_pc, m_cnt;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  wb_commit_stage #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .wb_ready(wb_ready),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd_we(mem_rd_we), .mem_rd(mem_rd),
    .mem_rd_data(mem_rd_data), .mem_is_break(mem_is_break),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_is_break(commit_is_break), .commit_cnt(commit_cnt), .rf_flat(rf_flat), .halted(halted)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (mem_valid && !m_halt && mem_rd_we && mem_rd == a) return mem_rd_data;
    return m_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_brk = 0; m_halt = 0; m_pc = '0; m_cnt = '0; m_inst = '0;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic we,
                       input logic [4:0] rd, input logic [63:0] d, input logic brk,
                       input logic [4:0] r1, input logic [4:0] r2);
    mem_valid = v; mem_pc = pc; mem_inst = inst; mem_rd_we = we; mem_rd = rd;
    mem_rd_data = d; mem_is_break = brk; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (mem_valid && !m_halt) begin
      if (mem_rd_we && mem_rd != 0) m_rf[mem_rd] = mem_rd_data;
      m_valid = 1; m_pc = mem_pc; m_inst = mem_inst; m_brk = mem_is_break; m_cnt++;
      if (mem_is_break) m_halt = 1;
    end else m_valid = 0;
    #1;
  endtask

  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic we,
                     input logic [4:0] rd, input logic [63:0] d, input logic brk,
                     input logic [4:0] r1, input logic [4:0] r2);
    drive(v, pc, inst, we, rd, d, brk, r1, r2);
    tick();
  endtask

  task automatic idle();
    cyc(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 0, rs1_addr, rs2_addr);
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_valid});
    if (m_valid) begin
      chk("commit_pc", commit_pc, m_pc);
      chk("commit_inst", {32'd0, commit_inst}, {32'd0, m_inst});
      chk("commit_is_break", {63'd0, commit_is_break}, {63'd0, m_brk});
    end
    chk("commit_cnt", commit_cnt, m_cnt);
    chk("halted", {63'd0, halted}, {63'd0, m_halt});
    chk("wb_ready", {63'd0, wb_ready}, {63'd0, !m_halt});
    for (int i = 0; i < 32; i++) chk($sformatf("rf_flat[x%0d]", i), rf_flat[i*64 +: 64], m_rf[i]);
    chk("rs1_data", rs1_data, exp_rd(rs1_addr));
    chk("rs2_data", rs2_data, exp_rd(rs2_addr));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    drive(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t1_valid", {63'd0, commit_valid}, 64'd0);
    chk("t1_cnt", commit_cnt, 64'd0);
    chk("t1_ready", {63'd0, wb_ready}, 64'd1);
    chk("t1_rf_zero", {63'd0, |rf_flat}, 64'd0);
    chk("t1_halted", {63'd0, halted}, 64'd0);
    idle();
    cyc(1, 64'h8000_0000, 32'h0050_0093, 1, 5'd1, 64'd5, 0, 5'd1, 5'd0);
    chk("t2_valid", {63'd0, commit_valid}, 64'd1);
    chk("t2_pc", commit_pc, 64'h8000_0000);
    chk("t2_x1", rf_flat[127:64], 64'd5);
    chk("t2_cnt", commit_cnt, 64'd1);
    cyc(1, 64'h8000_0004, 32'h0000_0013, 1, 5'd0, 64'hDEAD, 0, 5'd0, 5'd1);
    chk("t3_x0", rf_flat[63:0], 64'd0);
    chk("t3_rs1_x0", rs1_data, 64'd0);
    chk("t3_valid", {63'd0, commit_valid}, 64'd1);
    idle();
    chk("gap_valid", {63'd0, commit_valid}, 64'd0);
    drive(1, 64'h8000_0008, 32'h0070_0113, 1, 5'd2, 64'd7, 0, 5'd2, 5'd1);
    #2 chk("t4_bypass", rs1_data, 64'd7);
    chk("t4_rs2_old", rs2_data, 64'd5);
    tick();
    cyc(1, 64'h8000_000C, 32'h1234_5678, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd2, 5'd31);
    cyc(1, 64'h8000_0010, 32'h0000_0013, 0, 5'd31, 64'h1, 0, 5'd31, 5'd31);
    chk("no_we_x31", rf_flat[31*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
    idle(); idle();
    rst_n = 1'b0; model_clear();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1, 64'h8000_0100 + 64'(4*i), 32'h0000_0013 + 32'(i), 1, 5'(3+i), 64'(i*11+1), 0, 5'd3, 5'(4+i));
    cyc(1, 64'h8000_010C, 32'h0010_0073, 1, 5'd9, 64'h99, 1, 5'd9, 5'd5);
    chk("t5_valid", {63'd0, commit_valid}, 64'd1);
    chk("t5_brk", {63'd0, commit_is_break}, 64'd1);
    chk("t5_halted", {63'd0, halted}, 64'd1);
    chk("t5_ready", {63'd0, wb_ready}, 64'd0);
    chk("t5_cnt", commit_cnt, 64'd4);
    chk("t5_x9", rf_flat[9*64 +: 64], 64'h99);
    cyc(1, 64'h8000_0110, 32'h0000_0013, 1, 5'd10, 64'h55, 0, 5'd10, 5'd0);
    chk("t5_ignored_valid", {63'd0, commit_valid}, 64'd0);
    chk("t5_ignored_cnt", commit_cnt, 64'd4);
    chk("t5_ignored_x10", rf_flat[10*64 +: 64], 64'd0);
    idle();
    rst_n = 1'b0; model_clear();
    #3 rst_n = 1'b1;
    cyc(1, 64'h8000_0200, 32'h0000_0013, 1, 5'd4, 64'h44, 0, 5'd4, 5'd0);
    cyc(1, 64'h8000_0204, 32'h0010_0073, 0, 5'd0, 64'd0, 1, 5'd4, 5'd0);
    rst_n = 1'b0; model_clear();
    #1;
    chk("t6_valid", {63'd0, commit_valid}, 64'd0);
    chk("t6_halted", {63'd0, halted}, 64'd0);
    chk("t6_ready", {63'd0, wb_ready}, 64'd1);
    chk("t6_cnt", commit_cnt, 64'd0);
    chk("t6_brk", {63'd0, commit_is_break}, 64'd0);
    chk("t6_rf", {63'd0, |rf_flat}, 64'd0);
    drive(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    idle();
    chk("t6_run_ready", {63'd0, wb_ready}, 64'd1);
    cyc(1, 64'h8000_0300, 32'h0000_0013, 1, 5'd6, 64'h66, 0, 5'd6, 5'd0);
    chk("t6_restart_cnt", commit_cnt, 64'd1);
    idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
